// File: rtl/conv_result_tx.sv
// Framed byte-stream transmitter for convolution results: header, payload
// (each 16-bit result high byte first, element 0 first), then an 8-bit payload checksum.
//
// state     | meaning
// ----------|---------------------------------------------------------
// S_IDLE    | waiting for conv_done; nothing presented
// S_HDR     | header byte presented
// S_PAYLOAD | payload byte idx presented
// S_CSUM    | checksum byte presented with tx_last
module conv_result_tx #(
   parameter int          N_OUT = 4,
   parameter int          OUT_W = 16,
   parameter logic [7:0]  HDR   = 8'hA5
) (
   input  logic                     clk_spi,
   input  logic                     rst,
   input  logic [N_OUT*OUT_W-1:0]   conv_out,
   input  logic                     conv_done,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     tx_last,
   output logic                     busy,
   output logic                     overrun,
   input  logic                     ovr_clr
);

   localparam int N_BYTES = 2 * N_OUT;
   localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CSUM} state_t;

   state_t                   state;
   logic [N_OUT*OUT_W-1:0]   shadow;
   logic [7:0]               csum;
   logic [IDX_W-1:0]         idx;

   logic                     hs;
   logic                     last_byte;
   logic                     drop;
   logic [IDX_W-1:0]         idx_nx;
   logic [7:0]               csum_nx;
   logic [7:0]               byte_nx;
   logic [7:0]               byte_first;

   // Even index -> high byte of element i/2, odd index -> low byte (OUT_W is 16).
   function automatic logic [7:0] payload_byte(input logic [N_OUT*OUT_W-1:0] w,
                                               input logic [IDX_W-1:0]       i);
      int base;
      base = (int'(i) >> 1) * OUT_W + (i[0] ? 0 : 8);
      return w[base +: 8];
   endfunction

   assign hs         = tx_valid & tx_ready;
   assign last_byte  = (idx == IDX_W'(N_BYTES - 1));
   assign idx_nx     = idx + IDX_W'(1);
   assign csum_nx    = csum + tx_data;
   assign byte_nx    = payload_byte(shadow, idx_nx);
   assign byte_first = payload_byte(shadow, IDX_W'(0));
   // A pulse coinciding with the checksum handshake starts the next frame instead.
   assign drop       = conv_done && (state != S_IDLE) && !((state == S_CSUM) && hs);

   always_ff @(posedge clk_spi or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         shadow   <= '0;
         csum     <= '0;
         idx      <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (drop)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;

         case (state)
            S_IDLE: begin
               if (conv_done) begin
                  shadow   <= conv_out;
                  csum     <= '0;
                  idx      <= '0;
                  state    <= S_HDR;
                  tx_data  <= HDR;
                  tx_valid <= 1'b1;
                  tx_last  <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_HDR: begin
               if (hs) begin
                  idx     <= '0;
                  state   <= S_PAYLOAD;
                  tx_data <= byte_first;
               end
            end
            S_PAYLOAD: begin
               if (hs) begin
                  csum <= csum_nx;
                  if (last_byte) begin
                     state   <= S_CSUM;
                     tx_data <= csum_nx;
                     tx_last <= 1'b1;
                  end else begin
                     idx     <= idx_nx;
                     tx_data <= byte_nx;
                  end
               end
            end
            S_CSUM: begin
               if (hs) begin
                  if (conv_done) begin
                     shadow   <= conv_out;
                     csum     <= '0;
                     idx      <= '0;
                     state    <= S_HDR;
                     tx_data  <= HDR;
                     tx_last  <= 1'b0;
                  end else begin
                     state    <= S_IDLE;
                     tx_data  <= '0;
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     busy     <= 1'b0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/conv_result_tx.md
# conv_result_tx

Byte-stream transmitter for the convolution core's result bus. It snapshots the packed `conv_out` word when the core signals completion. It then emits a framed byte sequence (header, results high byte first, checksum) over a valid/ready handshake toward the SPI slave shift logic. It is the return path that pairs with the image/filter load path into the convolution core, and runs entirely in the `clk_spi` domain.

## Interface
- `N_OUT`, default 4: number of convolution results per frame.
- `OUT_W`, default 16: width of each result; must be 16 (two bytes per result).
- `HDR`, default 8'hA5: frame header byte.

- `clk_spi`  in  1: sole clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `conv_out`  in  N_OUT*OUT_W: packed results; element k = `conv_out[16k+15:16k]`.
- `conv_done`  in  1: single-cycle pulse; `conv_out` is valid in this cycle.
- `tx_data`  out  8: current frame byte.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: downstream accepts the byte.
- `tx_last`  out  1: high with the checksum byte.
- `busy`  out  1: frame in progress (state != IDLE).
- `overrun`  out  1: sticky; a `conv_done` pulse was dropped.
- `ovr_clr`  in  1: synchronous clear of `overrun`.

## Operation
- FSM states: IDLE, HDR, PAYLOAD, CSUM.
- IDLE: `conv_done`=1 captures `conv_out` into a shadow register, clears the checksum accumulator and byte index, and moves to HDR.
- HDR: `tx_data`=`HDR`. On handshake, move to PAYLOAD with index 0.
- PAYLOAD: byte index i runs 0..2*N_OUT-1.
  - Byte i = high byte of element i/2 when i is even, low byte when i is odd.
  - Elements go out in order k=0 first.
  - On each handshake, add the byte to the 8-bit checksum (mod 256) and increment i.
  - Handshake on i=2*N_OUT-1 moves to CSUM.
- CSUM: `tx_data` = checksum of payload bytes only (header excluded), `tx_last`=1.
  - On handshake, go to IDLE.
  - If `conv_done`=1 in that same cycle, capture the new `conv_out` and go to HDR directly. This is not an overrun.
- Handshake: a byte transfers in a cycle where `tx_valid`&&`tx_ready`. While `tx_valid`=1 and `tx_ready`=0, `tx_data`/`tx_last` hold stable and `tx_valid` stays 1. `tx_ready` may be high while `tx_valid` is low; this has no effect.
- `conv_done` in any non-IDLE cycle not covered by the CSUM exception is dropped:
  - the shadow register is unchanged;
  - `overrun` sets the next cycle.
- `ovr_clr`: clears `overrun`. If a drop occurs in the same cycle, the set wins.
- `conv_out` changes after capture have no effect on the frame in flight.
- `tx_data`=0 and `tx_last`=0 whenever `tx_valid`=0.
- Frame length = 2*N_OUT+2 bytes (10 at defaults).

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `tx_last`=0, `busy`=0, `overrun`=0, FSM=IDLE, shadow and checksum registers = 0.
- Reset asserted mid-frame aborts the frame immediately; no partial bytes follow after release.
- All outputs are registered.
- Capture latency: `conv_done` high at edge n gives `tx_valid`=1 with `HDR` after edge n (one cycle), with `busy`=1 from the same point.
- Throughput: with `tx_ready` held at 1, one byte per cycle.
  - Frame occupies 2*N_OUT+2 consecutive cycles.
  - Back-to-back frames via the CSUM exception have no idle gap.
- `busy` deasserts the cycle after the final handshake, unless a new frame was captured in that cycle.

## Test plan
- Basic frame. Stimulus: reset, then `conv_out` = {16'hFFFF,16'h0102,16'h0034,16'h0012} (element 0 = 0x0012) with a `conv_done` pulse and `tx_ready`=1. Required: bytes A5 00 12 00 34 01 02 FF FF 47 on 10 consecutive cycles, `tx_last` only on 47, `busy` low afterwards.
- Backpressure. Same frame with `tx_ready` toggling pseudo-randomly. Required:
  - identical byte sequence;
  - `tx_data` stable while stalled;
  - no byte duplicated or skipped.
- Overrun. Pulse `conv_done` again during the PAYLOAD state. Required:
  - frame content unchanged (still ends in 47);
  - `overrun`=1 persists after the frame;
  - `ovr_clr` pulse clears it to 0.
- Back-to-back. Pulse `conv_done` with all-zero `conv_out` coincident with the checksum handshake. Required:
  - next cycle `tx_data`=A5;
  - second frame A5 00×8 00;
  - `overrun` stays 0.
- Reset mid-frame. Assert `rst` during byte 4 for 1 cycle. Required:
  - all outputs 0 asynchronously;
  - after release, nothing is emitted until the next `conv_done`;
  - the next frame is correct.
- Capture isolation. Change `conv_out` every cycle after `conv_done`. Required: frame reflects only the value present in the `conv_done` cycle.
